// File: rtl/dfh_csr_responder_pkg.sv
// Shared types and constants for the DFH CSR responder: DFH header layout,
// fixed register offsets, AXI response codes and channel FSM states.
package dfh_csr_pkg;

    typedef struct packed {
        logic [3:0]  feature_type;
        logic [18:0] rsvd;
        logic        eol;
        logic [23:0] next_offset;
        logic [3:0]  rev;
        logic [11:0] id;
    } dfh_t;

    localparam int unsigned DFH_ADDR    = 'h0;
    localparam int unsigned GUID_L_ADDR = 'h8;
    localparam int unsigned GUID_H_ADDR = 'h10;

    localparam logic [3:0] DFH_FEATURE_TYPE = 4'h1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    // Assemble the DFH word from the per-instance feature fields.
    function automatic dfh_t make_dfh(input logic [11:0] id,
                                      input logic [3:0]  rev,
                                      input logic [23:0] next_offset,
                                      input logic        eol);
        dfh_t d;
        d.feature_type = DFH_FEATURE_TYPE;
        d.rsvd         = '0;
        d.eol          = eol;
        d.next_offset  = next_offset;
        d.rev          = rev;
        d.id           = id;
        return d;
    endfunction

endpackage

// File: rtl/dfh_csr_responder_if.sv
// AXI4-Lite (64-bit data) bus bundle between the MMIO fabric and the
// DFH CSR responder.
interface dfh_csr_responder_if #(
    parameter int ADDR_W = 16
) ();
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/dfh_csr_responder_regfile.sv
// Register file for one DFH feature: address decode, read mux and the
// byte-strobed scratch register. Only addr[ADDR_W-1:3] takes part in decode.
// Optional: DFH_CSR_SLVERR_EN makes unmapped reads and writes to unmapped or
// read-only offsets answer SLVERR instead of OKAY.
module dfh_csr_regfile
    import dfh_csr_pkg::*;
#(
    parameter int                ADDR_W          = 16,
    parameter logic [127:0]      FEATURE_GUID    = 128'h0,
    parameter logic [ADDR_W-1:0] SCRATCH_ADDR    = 'h18,
    parameter logic [63:0]       SCRATCH_RESET   = 64'h0,
    parameter logic [11:0]       FEATURE_ID      = 12'h0,
    parameter logic [3:0]        FEATURE_REV     = 4'h0,
    parameter logic [23:0]       NEXT_DFH_OFFSET = 24'h0,
    parameter logic              END_OF_LIST     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    input  logic [ADDR_W-1:0] raddr,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp,
    output logic [1:0]        bresp,
    output logic [63:0]       scratch
);

    localparam int IW = ADDR_W - 3;

    localparam logic [IW-1:0] DFH_IDX    = IW'(DFH_ADDR >> 3);
    localparam logic [IW-1:0] GUID_L_IDX = IW'(GUID_L_ADDR >> 3);
    localparam logic [IW-1:0] GUID_H_IDX = IW'(GUID_H_ADDR >> 3);
    localparam logic [IW-1:0] SCR_IDX    = SCRATCH_ADDR[ADDR_W-1:3];

    localparam dfh_t DFH_VAL = make_dfh(FEATURE_ID, FEATURE_REV, NEXT_DFH_OFFSET, END_OF_LIST);

    // The scratch register must not alias the fixed header words.
    if ((SCRATCH_ADDR[2:0] != 3'b000) || (SCR_IDX == DFH_IDX) ||
        (SCR_IDX == GUID_L_IDX) || (SCR_IDX == GUID_H_IDX)) begin : g_bad_scratch_addr
        $error("dfh_csr_regfile: SCRATCH_ADDR must be 8-aligned and distinct from 'h0/'h8/'h10");
    end

    logic [IW-1:0] ridx;
    logic [IW-1:0] widx;
    logic          wr_scratch;
    logic [63:0]   scratch_q;
    logic          unused_addr_bits;

    assign ridx             = raddr[ADDR_W-1:3];
    assign widx             = waddr[ADDR_W-1:3];
    assign wr_scratch       = (widx == SCR_IDX);
    assign unused_addr_bits = ^{waddr[2:0], raddr[2:0]};
    assign scratch          = scratch_q;

    // Scratch register: reloads on reset, otherwise updates the strobed lanes on a committed write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scratch_q <= SCRATCH_RESET;
        end else if (we && wr_scratch) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb[i]) scratch_q[8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read mux; the scratch value seen here is pre-write when a write commits on the same edge.
    always_comb begin
        rdata = '0;
        rresp = RESP_OKAY;
        if (ridx == DFH_IDX) begin
            rdata = DFH_VAL;
        end else if (ridx == GUID_L_IDX) begin
            rdata = FEATURE_GUID[63:0];
        end else if (ridx == GUID_H_IDX) begin
            rdata = FEATURE_GUID[127:64];
        end else if (ridx == SCR_IDX) begin
            rdata = scratch_q;
        end else begin
`ifdef DFH_CSR_SLVERR_EN
            rresp = RESP_SLVERR;
`else
            rresp = RESP_OKAY;
`endif
        end
    end

    // Write response: only the scratch register is writable.
    always_comb begin
`ifdef DFH_CSR_SLVERR_EN
        bresp = wr_scratch ? RESP_OKAY : RESP_SLVERR;
`else
        bresp = RESP_OKAY;
`endif
    end

endmodule

// File: rtl/dfh_csr_responder.sv
// AXI4-Lite MMIO responder for a single DFH feature (DFH word, 128-bit GUID,
// one scratch register). Holds independent write and read channel FSMs; the
// register file sits in dfh_csr_regfile.
// Optional: DFH_CSR_SLVERR_EN enables SLVERR responses for unmapped/read-only
// accesses (see dfh_csr_regfile).
module dfh_csr_responder
    import dfh_csr_pkg::*;
#(
    parameter int                ADDR_W          = 16,
    parameter logic [127:0]      FEATURE_GUID    = 128'h0,
    parameter logic [ADDR_W-1:0] SCRATCH_ADDR    = 'h18,
    parameter logic [63:0]       SCRATCH_RESET   = 64'h0,
    parameter logic [11:0]       FEATURE_ID      = 12'h0,
    parameter logic [3:0]        FEATURE_REV     = 4'h0,
    parameter logic [23:0]       NEXT_DFH_OFFSET = 24'h0,
    parameter logic              END_OF_LIST     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    dfh_csr_responder_if.slave bus,
    output logic [63:0]        scratch_o
);

    w_state_e          w_state;
    w_state_e          w_next;
    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] aw_addr;
    logic [63:0]       w_data;
    logic [7:0]        w_strb;
    logic [1:0]        bresp_q;
    logic              commit;
    logic              aw_fire;
    logic              w_fire;

    r_state_e          r_state;
    r_state_e          r_next;
    logic [63:0]       rdata_q;
    logic [1:0]        rresp_q;
    logic              ar_fire;

    logic [63:0]       rf_rdata;
    logic [1:0]        rf_rresp;
    logic [1:0]        rf_bresp;

    dfh_csr_regfile #(
        .ADDR_W          (ADDR_W),
        .FEATURE_GUID    (FEATURE_GUID),
        .SCRATCH_ADDR    (SCRATCH_ADDR),
        .SCRATCH_RESET   (SCRATCH_RESET),
        .FEATURE_ID      (FEATURE_ID),
        .FEATURE_REV     (FEATURE_REV),
        .NEXT_DFH_OFFSET (NEXT_DFH_OFFSET),
        .END_OF_LIST     (END_OF_LIST)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (commit),
        .waddr   (aw_addr),
        .wdata   (w_data),
        .wstrb   (w_strb),
        .raddr   (bus.araddr),
        .rdata   (rf_rdata),
        .rresp   (rf_rresp),
        .bresp   (rf_bresp),
        .scratch (scratch_o)
    );

    assign aw_fire = bus.awvalid && bus.awready;
    assign w_fire  = bus.wvalid && bus.wready;
    assign ar_fire = bus.arvalid && bus.arready;

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Write FSM next state and channel outputs; a ready drops once its beat is latched.
    always_comb begin
        w_next      = w_state;
        commit      = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = bresp_q;
        case (w_state)
            W_IDLE: begin
                bus.awready = !aw_held;
                bus.wready  = !w_held;
                if (aw_held && w_held) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // AW/W capture latches and the response code sampled at commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_addr <= bus.awaddr;
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= bus.wdata;
                w_strb <= bus.wstrb;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= rf_bresp;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Read FSM next state and channel outputs.
    always_comb begin
        r_next      = r_state;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = rdata_q;
        bus.rresp   = rresp_q;
        case (r_state)
            R_IDLE: begin
                bus.arready = 1'b1;
                if (bus.arvalid) r_next = R_RESP;
            end
            R_RESP: begin
                bus.rvalid = 1'b1;
                if (bus.rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read data capture on the AR handshake; held until the R handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_fire) begin
            rdata_q <= rf_rdata;
            rresp_q <= rf_rresp;
        end
    end

endmodule

// File: tb/tb_dfh_csr_responder.sv
// Self-checking bench for dfh_csr_responder with scoreboard queues for
// read data/response and write response.
module tb_dfh_csr_responder;
    import dfh_csr_pkg::*;

    localparam logic [127:0] GUID     = 128'h3E7B60A0DF2D4850AA31F54A3E403501;
    localparam logic [63:0]  SCR_RST  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0]  EXP_DFH  = 64'h1000_0100_0000_00AA;
    localparam logic [63:0]  EXP_GL   = 64'hAA31F54A3E403501;
    localparam logic [63:0]  EXP_GH   = 64'h3E7B60A0DF2D4850;
`ifdef DFH_CSR_SLVERR_EN
    localparam logic [1:0]   EXP_ERR  = 2'b10;
`else
    localparam logic [1:0]   EXP_ERR  = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [63:0] scratch_o;
    int total = 0;
    int bad = 0;

    logic [65:0] rq[$];
    logic [1:0]  bq[$];

    always #5 clk = ~clk;

    dfh_csr_responder_if #(.ADDR_W(16)) bus ();

    dfh_csr_responder #(
        .ADDR_W          (16),
        .FEATURE_GUID    (GUID),
        .SCRATCH_ADDR    (16'h18),
        .SCRATCH_RESET   (SCR_RST),
        .FEATURE_ID      (12'h0AA),
        .FEATURE_REV     (4'h0),
        .NEXT_DFH_OFFSET (24'h0),
        .END_OF_LIST     (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .scratch_o (scratch_o)
    );

    task automatic do_read(input logic [15:0] a, input logic [63:0] ed, input logic [1:0] er,
                           input int hold, input string nm);
        logic [65:0] e;
        int n;
        rq.push_back({er, ed});
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        n = 0;
        while (bus.arready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        total++;
        if (bus.rvalid !== 1'b1) begin
            bad++; $display("FAIL %s_latency rvalid=%b required 1", nm, bus.rvalid);
        end
        for (int i = 0; i < hold; i++) begin
            e = rq[0];
            total++;
            if ({bus.rvalid, bus.arready, bus.rresp, bus.rdata} !== {2'b10, e}) begin
                bad++;
                $display("FAIL %s_hold%0d rv/arrdy/resp/data=%b/%b/%b/%h required 1/0/%b/%h",
                         nm, i, bus.rvalid, bus.arready, bus.rresp, bus.rdata, e[65:64], e[63:0]);
            end
            @(posedge clk); #1;
        end
        e = rq.pop_front();
        total++;
        if (bus.rvalid !== 1'b1 || {bus.rresp, bus.rdata} !== e) begin
            bad++;
            $display("FAIL %s_data rvalid=%b resp=%b data=%h required 1 %b %h",
                     nm, bus.rvalid, bus.rresp, bus.rdata, e[65:64], e[63:0]);
        end
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        total++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
            bad++; $display("FAIL %s_done rvalid=%b arready=%b required 0 1", nm, bus.rvalid, bus.arready);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int lead, input int hold, input logic [1:0] er, input string nm);
        logic [1:0] e;
        int n;
        bq.push_back(er);
        bus.awaddr = a;
        bus.wdata  = d;
        bus.wstrb  = s;
        bus.bready = 1'b0;
        bus.wvalid = 1'b1;
        if (lead == 0) bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.wvalid  = 1'b0;
        bus.awvalid = 1'b0;
        for (int i = 0; i < lead; i++) begin
            total++;
            if ({bus.wready, bus.awready, bus.bvalid} !== 3'b010) begin
                bad++;
                $display("FAIL %s_wlatch wready/awready/bvalid=%b%b%b required 010",
                         nm, bus.wready, bus.awready, bus.bvalid);
            end
            if (i == lead - 1) bus.awvalid = 1'b1;
            @(posedge clk); #1;
        end
        bus.awvalid = 1'b0;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 10) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (bus.bvalid !== 1'b1 || n != 1) begin
            bad++; $display("FAIL %s_bvalid bvalid=%b after %0d cycles required 1 after 1", nm, bus.bvalid, n);
        end
        for (int i = 0; i < hold; i++) begin
            total++;
            if ({bus.bvalid, bus.awready, bus.wready, bus.bresp} !== {3'b100, bq[0]}) begin
                bad++;
                $display("FAIL %s_hold%0d bv/awrdy/wrdy/bresp=%b/%b/%b/%b required 1/0/0/%b",
                         nm, i, bus.bvalid, bus.awready, bus.wready, bus.bresp, bq[0]);
            end
            @(posedge clk); #1;
        end
        e = bq.pop_front();
        total++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== e) begin
            bad++; $display("FAIL %s_bresp bvalid=%b bresp=%b required 1 %b", nm, bus.bvalid, bus.bresp, e);
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        total++;
        if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
            bad++;
            $display("FAIL %s_single bvalid/awready/wready=%b%b%b required 011",
                     nm, bus.bvalid, bus.awready, bus.wready);
        end
    endtask

    task automatic check_scratch(input logic [63:0] ev, input string nm);
        total++;
        if (scratch_o !== ev) begin
            bad++; $display("FAIL %s scratch_o=%h required %h", nm, scratch_o, ev);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
            bad++;
            $display("FAIL reset_ctrl aw/w/ar rdy,bv,rv=%b%b%b%b%b required 11100",
                     bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid);
        end
        total++;
        if ({bus.bresp, bus.rresp, bus.rdata} !== 68'h0) begin
            bad++; $display("FAIL reset_data bresp=%b rresp=%b rdata=%h required 0", bus.bresp, bus.rresp, bus.rdata);
        end
        check_scratch(SCR_RST, "reset_scratch");
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_dfh_guid();
        do_read(16'h0,  EXP_DFH, 2'b00, 0, "dfh");
        do_read(16'h8,  EXP_GL,  2'b00, 0, "guid_l");
        do_read(16'h10, EXP_GH,  2'b00, 0, "guid_h");
    endtask

    task automatic test_scratch();
        do_read(16'h18, SCR_RST, 2'b00, 0, "scr_rst");
        do_write(16'h18, 64'hDEADBEEF_CAFEF00D, 8'hFF, 3, 0, 2'b00, "scr_wr_full");
        check_scratch(64'hDEADBEEF_CAFEF00D, "scr_full_o");
        do_read(16'h18, 64'hDEADBEEF_CAFEF00D, 2'b00, 0, "scr_rd_full");
        do_write(16'h18, 64'h11111111_22222222, 8'h0F, 0, 0, 2'b00, "scr_wr_part");
        do_read(16'h1C, 64'hDEADBEEF_22222222, 2'b00, 0, "scr_rd_part");
    endtask

    task automatic test_backpressure();
        do_read(16'h18, 64'hDEADBEEF_22222222, 2'b00, 5, "bp_rd");
        do_write(16'h18, 64'h0F0F0F0F_33333333, 8'hF0, 1, 4, 2'b00, "bp_wr");
        do_read(16'h18, 64'h0F0F0F0F_22222222, 2'b00, 0, "bp_rd2");
    endtask

    task automatic test_unmapped();
        do_read(16'h40, 64'h0, EXP_ERR, 0, "unm_rd");
        do_write(16'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, EXP_ERR, "ro_wr");
        do_read(16'h8, EXP_GL, 2'b00, 0, "ro_guid_l");
        do_write(16'h40, 64'h5555_5555_5555_5555, 8'hFF, 2, 0, EXP_ERR, "unm_wr");
        do_read(16'h18, 64'h0F0F0F0F_22222222, 2'b00, 0, "unm_scr");
    endtask

    task automatic test_same_cycle();
        logic [65:0] e;
        rq.push_back({2'b00, 64'h0F0F0F0F_22222222});
        bus.awaddr = 16'h18; bus.wdata = 64'h7777_8888_9999_AAAA; bus.wstrb = 8'hFF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0; bus.rready = 1'b0;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 16'h18; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        total++;
        if ({bus.bvalid, bus.rvalid} !== 2'b11) begin
            bad++; $display("FAIL same_valid bvalid/rvalid=%b%b required 11", bus.bvalid, bus.rvalid);
        end
        e = rq.pop_front();
        total++;
        if ({bus.rresp, bus.rdata} !== e) begin
            bad++; $display("FAIL same_old rdata=%h required %h", bus.rdata, e[63:0]);
        end
        check_scratch(64'h7777_8888_9999_AAAA, "same_new_o");
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        do_read(16'h18, 64'h7777_8888_9999_AAAA, 2'b00, 0, "same_after");
    endtask

    task automatic test_reset_mid();
        int n;
        bus.awaddr = 16'h18; bus.wdata = 64'h5A5A_5A5A_5A5A_5A5A; bus.wstrb = 8'hFF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        bus.araddr = 16'h0; bus.arvalid = 1'b1; bus.rready = 1'b0;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({bus.bvalid, bus.rvalid} !== 2'b11) begin
            bad++; $display("FAIL mid_busy bvalid/rvalid=%b%b required 11", bus.bvalid, bus.rvalid);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready} !== 5'b00111) begin
            bad++;
            $display("FAIL mid_rst bv/rv/awrdy/wrdy/arrdy=%b%b%b%b%b required 00111",
                     bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready);
        end
        check_scratch(SCR_RST, "mid_rst_scratch");
        rst_n = 1'b1;
        // A lone W beat latched before reset must not pair with a later AW.
        bus.wdata = 64'hBAD0_BAD0_BAD0_BAD0; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.awaddr = 16'h18; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if ({bus.bvalid, bus.wready, bus.awready} !== 3'b010) begin
            bad++;
            $display("FAIL mid_latch_clr bvalid/wready/awready=%b%b%b required 010",
                     bus.bvalid, bus.wready, bus.awready);
        end
        bus.wdata = 64'h0000_1111_2222_3333; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        total++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
            bad++; $display("FAIL mid_complete bvalid=%b bresp=%b required 1 00", bus.bvalid, bus.bresp);
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        do_read(16'h18, 64'h0000_1111_2222_3333, 2'b00, 0, "mid_final");
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.awaddr = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0;
        bus.rready  = 1'b0;
        test_reset();
        test_dfh_guid();
        test_scratch();
        test_backpressure();
        test_unmapped();
        test_same_cycle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
